reorder_buffer: RTL and testbench

// In-order retirement queue between issue and the architectural register file. Issue allocates
// one tagged entry per instruction; the CDB writes results back out of order; the head retires in

---
 rtl/reorder_buffer.sv | 153 +++++++++++++++
 tb/tb_reorder_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement queue: issue allocates tagged entries, the CDB fills results out of order,
// and the head retires in order into the regfile. A mispredicted branch at the head flushes everything.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  input  logic        issue_has_dest,
  input  logic        issue_is_branch,
  output logic        full,
  output logic [31:0] alloc_tag,
  input  logic        wb_en,
  input  logic [31:0] wb_tag,
  input  logic [31:0] wb_value,
  input  logic        wb_mispredict,
  input  logic [31:0] wb_target,
  input  logic [31:0] qry_tag_1,
  input  logic [31:0] qry_tag_2,
  output logic        qry_ready_1,
  output logic        qry_ready_2,
  output logic [31:0] qry_value_1,
  output logic [31:0] qry_value_2,
  output logic        commit_en,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_value,
  output logic [31:0] commit_tag,
  output logic        clear,
  output logic [31:0] redirect_pc
);

  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0] busy_q, ready_q, has_dest_q, is_branch_q, mispredict_q;
  logic [4:0]       rd_q     [DEPTH];
  logic [31:0]      value_q  [DEPTH];
  logic [31:0]      target_q [DEPTH];

  logic [TAG_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [TAG_W-1:0] wb_idx, qry_idx_1, qry_idx_2;
  logic             do_alloc, do_wb, do_retire, do_flush;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign alloc_tag = 32'(tail_q);

  assign wb_idx    = wb_tag[TAG_W-1:0];
  assign qry_idx_1 = qry_tag_1[TAG_W-1:0];
  assign qry_idx_2 = qry_tag_2[TAG_W-1:0];

  // Everything is gated by rdy_in so a frozen pipeline changes no state at all.
  assign do_alloc  = rdy_in && issue_en && !full;
  assign do_wb     = rdy_in && wb_en && busy_q[wb_idx];
  assign do_retire = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign do_flush  = do_retire && mispredict_q[head_q];

  // Operand lookup forwards a same-cycle CDB broadcast ahead of the stored result.
  always_comb begin
    qry_ready_1 = ready_q[qry_idx_1];
    qry_value_1 = value_q[qry_idx_1];
    qry_ready_2 = ready_q[qry_idx_2];
    qry_value_2 = value_q[qry_idx_2];
    if (wb_en && (wb_tag == qry_tag_1)) begin
      qry_ready_1 = 1'b1;
      qry_value_1 = wb_value;
    end
    if (wb_en && (wb_tag == qry_tag_2)) begin
      qry_ready_2 = 1'b1;
      qry_value_2 = wb_value;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      has_dest_q   <= '0;
      is_branch_q  <= '0;
      mispredict_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else if (do_flush) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wb) begin
        ready_q[wb_idx]      <= 1'b1;
        mispredict_q[wb_idx] <= wb_mispredict && is_branch_q[wb_idx];
      end
      if (do_retire) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + TAG_W'(1);
      end
      // The tail slot is never busy while allocation is allowed, so it cannot collide with wb/retire.
      if (do_alloc) begin
        busy_q[tail_q]       <= 1'b1;
        ready_q[tail_q]      <= 1'b0;
        mispredict_q[tail_q] <= 1'b0;
        has_dest_q[tail_q]   <= issue_has_dest;
        is_branch_q[tail_q]  <= issue_is_branch;
        tail_q               <= tail_q + TAG_W'(1);
      end
      case ({do_alloc, do_retire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_alloc && !do_flush) begin
      rd_q[tail_q] <= issue_rd;
    end
    if (do_wb && !do_flush) begin
      value_q[wb_idx]  <= wb_value;
      target_q[wb_idx] <= wb_target;
    end
  end

  // Commit strobe and clear are single-cycle pulses; the data fields hold until the next retire.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_en    <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      clear        <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      commit_en <= 1'b0;
      clear     <= 1'b0;
      if (do_retire) begin
        commit_en    <= has_dest_q[head_q] && (rd_q[head_q] != 5'd0);
        commit_rd    <= rd_q[head_q];
        commit_value <= value_q[head_q];
        commit_tag   <= 32'(head_q);
      end
      if (do_flush) begin
        clear       <= 1'b1;
        redirect_pc <= target_q[head_q];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, out-of-order writeback, full, wrap, mispredict flush,
// rd=0 suppression and operand bypass, each checked against hand-computed values.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        issue_has_dest;
  logic        issue_is_branch;
  logic        full;
  logic [31:0] alloc_tag;
  logic        wb_en;
  logic [31:0] wb_tag;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic [31:0] wb_target;
  logic [31:0] qry_tag_1, qry_tag_2;
  logic        qry_ready_1, qry_ready_2;
  logic [31:0] qry_value_1, qry_value_2;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [31:0] commit_tag;
  logic        clear;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_has_dest(issue_has_dest),
    .issue_is_branch(issue_is_branch), .full(full), .alloc_tag(alloc_tag),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_value(wb_value), .wb_mispredict(wb_mispredict),
    .wb_target(wb_target), .qry_tag_1(qry_tag_1), .qry_tag_2(qry_tag_2),
    .qry_ready_1(qry_ready_1), .qry_ready_2(qry_ready_2),
    .qry_value_1(qry_value_1), .qry_value_2(qry_value_2),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .clear(clear), .redirect_pc(redirect_pc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of issue/writeback inputs, then returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic ien, input logic [4:0] rd, input logic hd, input logic br,
                               input logic wen, input logic [31:0] wtag, input logic [31:0] wval,
                               input logic wmis, input logic [31:0] wtgt);
    issue_en        = ien;
    issue_rd        = rd;
    issue_has_dest  = hd;
    issue_is_branch = br;
    wb_en           = wen;
    wb_tag          = wtag;
    wb_value        = wval;
    wb_mispredict   = wmis;
    wb_target       = wtgt;
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulseReset();
    #2 rst_in = 1'b0;
    #2 rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    issue_en = 0; issue_rd = 0; issue_has_dest = 0; issue_is_branch = 0;
    wb_en = 0; wb_tag = 0; wb_value = 0; wb_mispredict = 0; wb_target = 0;
    qry_tag_1 = 0; qry_tag_2 = 0;
    #2;
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_alloc_tag", alloc_tag, 32'd0);
    checkOutput("reset_commit_en", 32'(commit_en), 32'd0);
    checkOutput("reset_clear", 32'(clear), 32'd0);
    #10 rst_in = 1'b1;

    // Reset mid-run after five issues and one commit
    for (int i = 0; i < 5; i++) applyStimulus(1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'd0, 32'h55, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_commit_en", 32'(commit_en), 32'd1);
    checkOutput("pre_rst_commit_value", commit_value, 32'h55);
    checkOutput("pre_rst_alloc_tag", alloc_tag, 32'd5);
    #2 rst_in = 1'b0;
    #1;
    checkOutput("mid_rst_full", 32'(full), 32'd0);
    checkOutput("mid_rst_alloc_tag", alloc_tag, 32'd0);
    checkOutput("mid_rst_commit_en", 32'(commit_en), 32'd0);
    checkOutput("mid_rst_commit_rd", 32'(commit_rd), 32'd0);
    checkOutput("mid_rst_commit_value", commit_value, 32'd0);
    checkOutput("mid_rst_commit_tag", commit_tag, 32'd0);
    checkOutput("mid_rst_clear", 32'(clear), 32'd0);
    checkOutput("mid_rst_redirect_pc", redirect_pc, 32'd0);
    #1 rst_in = 1'b1;

    // Out-of-order writeback, in-order commit
    applyStimulus(1, 5'd1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd2, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'd2, 32'd30, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'd0, 32'd10, 0, 0);
    checkOutput("ooo_no_early_commit", 32'(commit_en), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'd1, 32'd20, 0, 0);
    checkOutput("ooo_c0_en", 32'(commit_en), 32'd1);
    checkOutput("ooo_c0_rd", 32'(commit_rd), 32'd1);
    checkOutput("ooo_c0_value", commit_value, 32'd10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ooo_c1_rd", 32'(commit_rd), 32'd2);
    checkOutput("ooo_c1_value", commit_value, 32'd20);
    checkOutput("ooo_c1_tag", commit_tag, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ooo_c2_en", 32'(commit_en), 32'd1);
    checkOutput("ooo_c2_rd", 32'(commit_rd), 32'd3);
    checkOutput("ooo_c2_value", commit_value, 32'd30);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ooo_drained_en", 32'(commit_en), 32'd0);
    checkOutput("ooo_alloc_tag", alloc_tag, 32'd3);

    // rd=0 commit suppression and operand bypass (entry gets tag 3)
    applyStimulus(1, 5'd0, 1, 0, 0, 0, 0, 0, 0);
    issue_en = 0; qry_tag_1 = 32'd3; qry_tag_2 = 32'd5;
    #1;
    checkOutput("qry_not_ready", 32'(qry_ready_1), 32'd0);
    wb_en = 1; wb_tag = 32'd3; wb_value = 32'd7;
    #1;
    checkOutput("qry_bypass_ready", 32'(qry_ready_1), 32'd1);
    checkOutput("qry_bypass_value", qry_value_1, 32'd7);
    checkOutput("qry2_other_tag", 32'(qry_ready_2), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'd3, 32'd7, 0, 0);
    wb_en = 0;
    #1;
    checkOutput("qry_stored_ready", 32'(qry_ready_1), 32'd1);
    checkOutput("qry_stored_value", qry_value_1, 32'd7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd0_commit_en", 32'(commit_en), 32'd0);
    checkOutput("rd0_commit_tag", commit_tag, 32'd3);

    // Full: 16 issues, 17th ignored, one retire frees space
    pulseReset();
    for (int i = 0; i < 16; i++) applyStimulus(1, 5'(i + 1), 1, 0, 0, 0, 0, 0, 0);
    checkOutput("full_set", 32'(full), 32'd1);
    checkOutput("full_alloc_tag", alloc_tag, 32'd0);
    applyStimulus(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("full_17th_ignored", 32'(full), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'd0, 32'hAA, 0, 0);
    checkOutput("full_wb_still_full", 32'(full), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_cleared", 32'(full), 32'd0);
    checkOutput("full_commit_rd", 32'(commit_rd), 32'd1);
    checkOutput("full_commit_value", commit_value, 32'hAA);
    checkOutput("full_tail_kept", alloc_tag, 32'd0);

    // Wrap: 40 issue/writeback/retire rounds
    pulseReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 5'((i % 31) + 1), 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 32'(i % 16), 32'(1000 + i), 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("wrap_tag_%0d", i), commit_tag, 32'(i % 16));
      checkOutput($sformatf("wrap_value_%0d", i), commit_value, 32'(1000 + i));
    end

    // Mispredict at head flushes the queue
    pulseReset();
    applyStimulus(1, 5'd1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd2, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'd0, 32'h44, 1, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_clear", 32'(clear), 32'd1);
    checkOutput("mis_redirect", redirect_pc, 32'h100);
    checkOutput("mis_commit_en", 32'(commit_en), 32'd1);
    checkOutput("mis_commit_value", commit_value, 32'h44);
    checkOutput("mis_alloc_tag", alloc_tag, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'd1, 32'h99, 0, 0);
    checkOutput("mis_clear_one_cycle", 32'(clear), 32'd0);
    checkOutput("mis_redirect_hold", redirect_pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_dropped_wb", 32'(commit_en), 32'd0);
    checkOutput("mis_commit_tag_hold", commit_tag, 32'd0);
    applyStimulus(1, 5'd4, 1, 0, 0, 0, 0, 0, 0);
    issue_en = 0; qry_tag_1 = 32'd0;
    #1;
    checkOutput("mis_realloc_not_ready", 32'(qry_ready_1), 32'd0);
    checkOutput("mis_realloc_tail", alloc_tag, 32'd1);

    // rdy_in low freezes allocation
    rdy_in = 1'b0;
    applyStimulus(1, 5'd6, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("frozen_alloc_tag", alloc_tag, 32'd1);
    rdy_in = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
